// File: rtl/demux_dispatcher_if.sv
// Handshake and demux-side bus of the dispatcher: word stream in, select/data out.
// The master side feeds words and channel readiness; the slave side is the dispatcher.
interface demux_dispatcher_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ch_ready;
    logic [1:0]       s;
    logic [WIDTH-1:0] x;
    logic             out_valid;

    modport master (
        output in_data, in_valid, ch_ready,
        input  in_ready, s, x, out_valid
    );

    modport slave (
        input  in_data, in_valid, ch_ready,
        output in_ready, s, x, out_valid
    );
endinterface

// File: rtl/demux_dispatcher.sv
// FIFO-buffered feeder for the 3-output demux: one word per cycle,
// destinations 1..3 chosen round-robin among ready channels.
module demux_dispatcher #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    demux_dispatcher_if.slave      bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   stalled
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_nxt;
    logic [1:0]       rr_ptr;
    logic [1:0]       grant;
    logic [1:0]       cand;
    logic             push;
    logic             pop;

    // No pass-through: a full FIFO refuses the push even if it pops this cycle.
    assign bus.in_ready = (level < (AW+1)'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready && !flush;
    assign pop          = (level != '0) && (bus.ch_ready != '0) && !flush;

    // Nearest ready destination after the last one served, wrapping 3 -> 1.
    always_comb begin
        grant = 2'd0;
        cand  = 2'd0;
        for (int unsigned i = 1; i <= 3; i++) begin
            cand = 2'((32'(rr_ptr) + i - 1) % 3 + 1);
            if (grant == 2'd0 && bus.ch_ready[cand - 2'd1]) grant = cand;
        end
    end

    always_comb begin
        level_nxt = level;
        if (flush)              level_nxt = '0;
        else if (push && !pop)  level_nxt = level + (AW+1)'(1);
        else if (pop && !push)  level_nxt = level - (AW+1)'(1);
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nxt = push ? RUN : IDLE;
                RUN:     if (level_nxt == '0)           state_nxt = IDLE;
                         else if (bus.ch_ready == '0)   state_nxt = STALL;
                         else                           state_nxt = RUN;
                STALL:   if (bus.ch_ready != '0)
                             state_nxt = (level_nxt == '0) ? IDLE : RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            rr_ptr        <= 2'd3;
            state         <= IDLE;
            stalled       <= 1'b0;
            bus.s         <= '0;
            bus.x         <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            level   <= level_nxt;
            state   <= state_nxt;
            stalled <= (state_nxt == STALL);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            if (pop) begin
                bus.s         <= grant;
                bus.x         <= mem[rd_ptr];
                bus.out_valid <= 1'b1;
                rr_ptr        <= grant;
            end else begin
                bus.s         <= '0;
                bus.x         <= '0;
                bus.out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end
endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed bench for demux_dispatcher: queue-based reference model compared every cycle,
// plus hand-computed expectations along the directed scenarios.
module tb_demux_dispatcher;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [2:0] level;
    logic       stalled;

    demux_dispatcher_if #(.WIDTH(WIDTH)) bus ();

    demux_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .bus     (bus),
        .level   (level),
        .stalled (stalled)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a word queue, last-served destination, expected registered outputs.
    logic [WIDTH-1:0] q[$];
    int               rr;
    int               m_old;
    int               d;
    bit               m_push;
    bit               m_pop;
    bit               m_stall;
    logic [1:0]       ms;
    logic [WIDTH-1:0] mx;
    logic             mov;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            rr      = 3;
            m_stall = 0;
            ms      = '0;
            mx      = '0;
            mov     = 1'b0;
        end else begin
            m_old  = q.size();
            m_push = bus.in_valid && (m_old < DEPTH) && !flush;
            m_pop  = (m_old > 0) && (bus.ch_ready != 3'b000) && !flush;
            ms  = '0;
            mx  = '0;
            mov = 1'b0;
            if (flush) q.delete();
            if (m_pop) begin
                d = rr;
                do d = (d % 3) + 1; while (!bus.ch_ready[d-1]);
                ms  = 2'(d);
                mx  = q.pop_front();
                mov = 1'b1;
                rr  = d;
            end
            if (m_push) q.push_back(bus.in_data);
            m_stall = !flush && (m_old > 0) && (bus.ch_ready == 3'b000);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("s",         32'(bus.s),         32'(ms));
            chk("x",         32'(bus.x),         32'(mx));
            chk("out_valid", 32'(bus.out_valid), 32'(mov));
            chk("level",     32'(level),         32'(q.size()));
            chk("in_ready",  32'(bus.in_ready),  32'(q.size() < DEPTH));
            chk("stalled",   32'(stalled),       32'(m_stall));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        tick();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.ch_ready = 3'b000;
        tick();
        tick();
        chk("rst_level",   32'(level),         32'd0);
        chk("rst_s",       32'(bus.s),         32'd0);
        chk("rst_x",       32'(bus.x),         32'd0);
        chk("rst_valid",   32'(bus.out_valid), 32'd0);
        chk("rst_stalled", 32'(stalled),       32'd0);
        chk("rst_ready",   32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        // 1: three words back-to-back, all channels ready
        bus.ch_ready = 3'b111;
        push(16'h432F);
        push(16'h322A);
        chk("t1_s0", 32'(bus.s), 32'h1);
        chk("t1_x0", 32'(bus.x), 32'h432F);
        push(16'h1011);
        chk("t1_s1", 32'(bus.s), 32'h2);
        chk("t1_x1", 32'(bus.x), 32'h322A);
        idle();
        chk("t1_s2", 32'(bus.s), 32'h3);
        chk("t1_x2", 32'(bus.x), 32'h1011);
        idle();
        chk("t1_s3",     32'(bus.s),   32'h0);
        chk("t1_x3",     32'(bus.x),   32'h0);
        chk("t1_level",  32'(level),   32'd0);
        chk("t1_stall",  32'(stalled), 32'd0);

        // 2: destination 2 never ready
        bus.ch_ready = 3'b101;
        push(16'hA001);
        push(16'hA002);
        chk("t2_s0", 32'(bus.s), 32'h1);
        chk("t2_x0", 32'(bus.x), 32'hA001);
        push(16'hA003);
        chk("t2_s1", 32'(bus.s), 32'h3);
        chk("t2_x1", 32'(bus.x), 32'hA002);
        push(16'hA004);
        chk("t2_s2", 32'(bus.s), 32'h1);
        idle();
        chk("t2_s3", 32'(bus.s), 32'h3);
        chk("t2_x3", 32'(bus.x), 32'hA004);
        idle();

        // 3: fill with no channel ready, refuse a 5th push, then release
        bus.ch_ready = 3'b000;
        push(16'hABCD);
        push(16'h010C);
        push(16'hC003);
        push(16'hC004);
        chk("t3_full_ready", 32'(bus.in_ready), 32'd0);
        push(16'hC005);
        chk("t3_level", 32'(level),   32'd4);
        chk("t3_stall", 32'(stalled), 32'd1);
        bus.ch_ready = 3'b111;
        idle();
        chk("t3_s0",      32'(bus.s),        32'h1);
        chk("t3_x0",      32'(bus.x),        32'hABCD);
        chk("t3_unstall", 32'(stalled),      32'd0);
        chk("t3_ready",   32'(bus.in_ready), 32'd1);
        repeat (4) idle();

        // 4: push and pop in the same cycle at level 3
        bus.ch_ready = 3'b000;
        push(16'hB001);
        push(16'hB002);
        push(16'hB003);
        bus.ch_ready = 3'b111;
        push(16'hB004);
        chk("t4_level", 32'(level), 32'd3);
        chk("t4_s0",    32'(bus.s), 32'h2);
        chk("t4_x0",    32'(bus.x), 32'hB001);
        repeat (3) idle();
        chk("t4_x3", 32'(bus.x), 32'hB004);
        idle();

        // 5: flush at level 2 while pushing
        bus.ch_ready = 3'b000;
        push(16'hD001);
        push(16'hD002);
        flush = 1'b1;
        push(16'hD003);
        flush = 1'b0;
        chk("t5_level", 32'(level),         32'd0);
        chk("t5_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_stall", 32'(stalled),       32'd0);
        bus.ch_ready = 3'b111;
        push(16'hD004);
        idle();
        chk("t5_s", 32'(bus.s), 32'h3);
        chk("t5_x", 32'(bus.x), 32'hD004);
        idle();

        // 6: asynchronous reset mid-burst
        bus.ch_ready = 3'b000;
        push(16'hE001);
        push(16'hE002);
        push(16'hE003);
        bus.ch_ready = 3'b111;
        push(16'hE004);
        chk("t6_pre_level", 32'(level),         32'd3);
        chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_pre_s",     32'(bus.s),         32'h1);
        #2;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("t6_s",     32'(bus.s),         32'd0);
        chk("t6_x",     32'(bus.x),         32'd0);
        chk("t6_level", 32'(level),         32'd0);
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        push(16'hF001);
        idle();
        chk("t6_post_s", 32'(bus.s), 32'h1);
        chk("t6_post_x", 32'(bus.x), 32'hF001);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux_dispatcher.md
Name: demux_dispatcher

Overview:
- Upstream feeder for the 16-bit, 3-output demux stage (select s[1:0], data x[15:0]).
- Accepts a word stream over a valid/ready handshake and buffers it in a small FIFO.
- Issues one word per cycle to the demux, choosing destinations 1..3 round-robin among channels that are ready.
- Drives s=00 (no destination) whenever nothing is dispatched.

Parameters:
WIDTH, 16, data word width; matches the demux x/y width.
DEPTH, 4, FIFO depth in words; must be a power of 2, at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous clear of FIFO contents and output register.
in_data  in  WIDTH  input word.
in_valid  in  1  in_data is valid.
in_ready  out  1  FIFO can accept a word this cycle.
ch_ready  in  3  bit k set: destination k+1 (s=k+1) can take a word.
s  out  2  demux select: 01/10/11 = destinations 1/2/3; 00 = none.
x  out  WIDTH  word for the demux; 0 when s=00.
out_valid  out  1  s/x carry a dispatched word this cycle.
level  out  $clog2(DEPTH)+1  current FIFO occupancy.
stalled  out  1  FSM is in STALL.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO empty, level=0, s=00, x=0, out_valid=0, stalled=0, state=IDLE.
  - Round-robin pointer is set to destination 3, so the first grant goes to destination 1.
  - Asserting reset mid-operation discards all buffered words immediately.
- in_ready = (level < DEPTH), combinational from level only.
  - No pass-through when full: push is refused at full even if a pop happens in the same cycle.
- Push: when in_valid && in_ready, in_data is written at the write pointer and the pointer wraps modulo DEPTH.
- Pop: occurs in a cycle where the FIFO is non-empty and ch_ready != 000.
- Simultaneous push and pop: level is unchanged and both pointers advance.
- Output register (s, x, out_valid) updates every cycle:
  - On pop:
    - s <= destination granted.
    - x <= head word.
    - out_valid <= 1.
    - Pointer <= granted destination.
  - Otherwise: s <= 00, x <= 0, out_valid <= 0.
- Latency:
  - A word accepted at edge N into an empty FIFO appears on s/x after edge N+1, provided a channel is ready.
  - Each word appears for exactly one cycle.
- Grant rule:
  - Search pointer+1, pointer+2, pointer+3, wrapping 3 -> 1.
  - Grant the first destination whose ch_ready bit is set.
  - Destinations with ch_ready=0 are skipped, not waited for.
- Word order is preserved: destinations vary, but FIFO order does not.
- FSM, registered, 3 states, evaluated on each edge from the current level/ch_ready:
  - IDLE: FIFO empty.
    - -> RUN when a push occurs.
  - RUN: FIFO non-empty and a pop occurred this edge.
    - -> IDLE when level becomes 0.
    - -> STALL when the FIFO is non-empty and ch_ready=000.
  - STALL: FIFO non-empty, ch_ready=000; stalled=1, no pop.
    - -> RUN when any ch_ready bit is set.
  - The pointer does not move in STALL or IDLE.
- flush=1 (synchronous):
  - Next edge: pointers and level cleared, s=00, x=0, out_valid=0, state=IDLE.
  - Any push in the same cycle is dropped.
  - The round-robin pointer is kept.
  - flush has priority over push and pop.
- level never exceeds DEPTH and never underflows. Pointer arithmetic wraps modulo DEPTH; level is tracked as a separate counter.

Test Plan:
1. Reset, then push 16'h432F, 16'h322A, 16'h1011 back-to-back with ch_ready=111 -> outputs on consecutive cycles are s=01 x=432F, then s=10 x=322A, then s=11 x=1011, then s=00 x=0000; level returns to 0 and state returns to IDLE.
2. ch_ready=101, push 4 words A1..A4 -> s sequence is 01,11,01,11; destination 2 is never selected; order is A1..A4.
3. ch_ready=000, push 16'hABCD, 16'h010C and 3 more words -> level reaches 4, in_ready=0, stalled=1, a 5th push is refused. Then ch_ready=111 -> ABCD is dispatched first, stalled=0, in_ready=1 on the cycle after the first pop.
4. At level=3, one push and one pop in the same cycle -> level stays 3; the pushed word emerges after the existing three.
5. Assert flush at level=2 while pushing -> the next cycle shows level=0, out_valid=0, IDLE; the pushed word never appears. A later push is granted to the destination after the last one served before flush.
6. Drop rst_n asynchronously mid-burst (level=3, out_valid=1) -> s=00, x=0, level=0, out_valid=0 immediately, without waiting for a clock. After release, the first grant is s=01.
